// File: rtl/coeff_axi_writer.sv
// coeff_axi_writer: loads a 5x5 signed 16-bit kernel into a coefficient slave
// through 13 single-beat AXI4-Lite writes, two coefficients per 32-bit word.
module coeff_axi_writer #(
    parameter logic [7:0]  BASE_ADDR      = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [399:0] kernel_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [31:0]  m_axi_awaddr,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [31:0]  m_axi_wdata,
    output logic [3:0]   m_axi_wstrb,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready
);

    localparam int unsigned NUM_COEF  = 25;
    localparam int unsigned NUM_WORDS = 13;
    localparam int unsigned KERN_W    = 16 * NUM_COEF;
    // Kernel padded to 16 words so every word slice is in range; the 26th
    // coefficient slot (upper half of the last word) reads as zero.
    localparam int unsigned PAD_W     = 512;
    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [3:0]       LAST_WORD = 4'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_RESP   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              r_state;
    logic [KERN_W-1:0]   r_kernel;
    logic [3:0]          r_k;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic [31:0]         r_awaddr;
    logic [31:0]         r_wdata;

    logic [PAD_W-1:0]    w_kern_pad;
    logic [3:0]          w_k_next;
    logic [31:0]         w_next_addr;
    logic [31:0]         w_next_data;
    logic                w_aw_ok;
    logic                w_w_ok;
    logic                w_timeout;

    // Address/data of the following word and per-channel completion this cycle
    assign w_kern_pad  = PAD_W'(r_kernel);
    assign w_k_next    = r_k + 4'd1;
    assign w_next_addr = 32'(BASE_ADDR) + 32'({w_k_next, 2'b00});
    assign w_next_data = w_kern_pad[{w_k_next, 5'd0} +: 32];
    assign w_aw_ok     = !r_awvalid || m_axi_awready;
    assign w_w_ok      = !r_wvalid  || m_axi_wready;
    assign w_timeout   = (r_cnt == CNT_MAX);

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;

    // Load sequencer: latch kernel, then one address/data/response per word
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_kernel  <= '0;
            r_k       <= 4'd0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_kernel  <= kernel_i;
                        r_k       <= 4'd0;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_awaddr  <= 32'(BASE_ADDR);
                        r_wdata   <= kernel_i[31:0];
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_aw_ok && w_w_ok) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RESP;
                    end else if (w_timeout) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= S_FINISH;
                    end else begin
                        r_awvalid <= !w_aw_ok;
                        r_wvalid  <= !w_w_ok;
                        r_cnt     <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (m_axi_bvalid && r_bready) begin
                        r_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= S_FINISH;
                        end else if (r_k == LAST_WORD) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                            r_state <= S_FINISH;
                        end else begin
                            r_k       <= w_k_next;
                            r_awaddr  <= w_next_addr;
                            r_wdata   <= w_next_data;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= S_SEND;
                        end
                    end else if (w_timeout) begin
                        r_bready <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/coeff_axi_writer.md
Name: coeff_axi_writer

Overview:
- AXI4-Lite write initiator that loads a 5x5 signed 16-bit kernel into the filter's coefficient slave port.
- Sits on the microblaze-side bus in place of, or next to, software writes.
- On a start pulse it latches the 25 coefficients, packs them two per 32-bit word, and issues 13 sequential single-beat writes.
- Reports completion or error per load.

Parameters:
- BASE_ADDR, 8'h00, byte address of the first coefficient word.
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting in any AXI wait state before aborting.

Ports:
- clk  in  1  bus clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- start_i  in  1  one-cycle load request; sampled only in IDLE.
- kernel_i  in  400  coefficient rc (row r, col c, 0..4) at bits [16*(5r+c)+15 : 16*(5r+c)]; latched on accepted start.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse when a load finishes or aborts.
- err_o  out  1  valid with done_o: 1 = aborted. Held until the next accepted start.
- m_axi_awaddr  out  32  write address.
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  byte strobes, always 4'hF.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; outputs busy_o, done_o, err_o, awvalid, wvalid and bready are 0; awaddr, wdata and the word index are 0; timeout counter 0.
- Reset mid-transfer drops all valids on that edge. No further beats or responses are tracked.
- Packing, word k = 0..12:
  - wdata[15:0] = coefficient index 2k.
  - wdata[31:16] = coefficient index 2k+1.
  - Index 25 does not exist, so word 12 has wdata[31:16] = 16'h0000.
  - awaddr = BASE_ADDR + 4k, zero-extended to 32 bits.
- IDLE:
  - start_i=1 latches kernel_i into an internal 400-bit register and sets k=0.
  - Clears err_o, sets busy_o, and goes to SEND.
- SEND:
  - awvalid and wvalid are both asserted from the first SEND cycle.
  - awvalid drops on the cycle after awready=1 is seen with awvalid=1. wvalid drops the same way on wready.
  - The two channels complete independently, in either order or the same cycle.
  - awaddr and wdata stay stable while the corresponding valid is high.
  - When both handshakes are done, go to RESP and assert bready.
- RESP:
  - On bvalid=1 with bready=1, deassert bready.
  - If bresp != 2'b00: go to FINISH with err.
  - Else if k=12: go to FINISH with no error.
  - Else: k <= k+1 and return to SEND.
- FINISH: lasts one cycle. done_o=1, busy_o=0, and err_o is set as recorded. Then go to IDLE.
- Timeout:
  - The counter clears on every entry to SEND or RESP and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES-1 without completing the state forces FINISH with err_o=1.
  - All valids and bready drop on that edge.
- start_i while not IDLE is ignored; no queuing. start_i in the FINISH cycle is also ignored.
- Each load performs exactly 13 address and 13 data handshakes on success. It never has more than one outstanding write.
- Latency with an always-ready slave and bvalid on the cycle after bready, per word: 1 SEND cycle + 2 RESP cycles. Total start to done_o = 1 + 13*3 + 1 = 41 cycles.

Test Plan:
- Load kernel with coeff rc = 16*r+c, slave always ready, OKAY responses. Required:
  - 13 writes at 0x00..0x30.
  - Word 0 = 32'h0001_0000; word 12 = 32'h0000_0044.
  - done_o at cycle 41 after start, err_o=0.
- Slave holds wready low 5 cycles after awready. Required: awvalid drops after its handshake; wvalid stays high with stable data until wready; the write completes correctly.
- bresp=2'b10 on word 3. Required: no write to 0x10; done_o with err_o=1.
- Slave never asserts awready, with TIMEOUT_CYCLES=16. Required: done_o with err_o=1 exactly 16 cycles after SEND entry; all valids low.
- Second start_i pulse while busy_o=1, with kernel_i changed. Required: it is ignored, and all written data match the kernel latched at the first start.
- rst=0 during RESP of word 6. Required: the next cycle shows all outputs 0; a fresh start afterwards writes from 0x00.
